count_ones_gen: RTL

//   Inverse of the serial ones counter: takes a ones count and builds a

---
 rtl/count_ones_gen.sv | 100 ++++++++++
 1 files changed

// File: rtl/count_ones_gen.sv
// Serial thermometer-code generator: builds a data_width-bit word with n ones at the LSBs, one bit per clock.
// Optional ONES_GEN_SERIAL_EN adds ser_bit/ser_valid, which stream each filled bit MSB first.
module count_ones_gen #(
   parameter int data_width  = 4,
   parameter int count_width = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [count_width-1:0] bit_count,
   output logic [data_width-1:0]  data,
   output logic                   done,
   output logic                   busy,
   output logic                   ovf
`ifdef ONES_GEN_SERIAL_EN
   ,
   output logic                   ser_bit,
   output logic                   ser_valid
`endif
);

   typedef enum logic [1:0] {IDLE, FILL, XFER} state_t;

   localparam logic [count_width-1:0] DW   = count_width'(data_width);
   localparam logic [count_width-1:0] LAST = count_width'(data_width - 1);

   state_t                 state_q, state_d;
   logic [data_width-1:0]  temp;
   logic [count_width-1:0] index;
   logic [count_width-1:0] n;
   logic                   ovf_int;
   logic                   fill_bit;

   // Bits are shifted in MSB first, so the bit entering now ends up at position LAST-index.
   assign fill_bit = (LAST - index) < n;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = FILL;
         FILL:    if (index == LAST) state_d = XFER;
         XFER:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data    <= '0;
         done    <= 1'b0;
         busy    <= 1'b0;
         ovf     <= 1'b0;
         temp    <= '0;
         index   <= '0;
         n       <= '0;
         ovf_int <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               n       <= (bit_count > DW) ? DW : bit_count;
               ovf_int <= bit_count > DW;
               temp    <= '0;
               index   <= '0;
               busy    <= 1'b1;
               done    <= 1'b0;
               ovf     <= 1'b0;
            end
            FILL: begin
               temp  <= {temp[data_width-2:0], fill_bit};
               index <= index + 1'b1;
            end
            XFER: begin
               data <= temp;
               ovf  <= ovf_int;
               done <= 1'b1;
               busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

`ifdef ONES_GEN_SERIAL_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ser_bit   <= 1'b0;
         ser_valid <= 1'b0;
      end else begin
         ser_valid <= (state_q == FILL);
         if (state_q == FILL) ser_bit <= fill_bit;
      end
   end
`endif

endmodule
